// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32I pipeline: data-memory req/ack access, load formatting, MEM/WB register.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module mem_access_stage #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_mem,
    input  logic [31:0]   alu_result_mem,
    input  logic [31:0]   rs2_data_mem,
    input  logic          mem_read_mem,
    input  logic          mem_write_mem,
    input  logic [2:0]    funct3_mem,
    input  logic [4:0]    rd_mem,
    input  logic          reg_write_mem,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_ack,
    output logic          mem_stall,
    output logic [31:0]   data_forward_mem,
    output logic          wb_valid,
    output logic          wb_reg_write,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    output logic          misalign_exc
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic          w_memop;
    logic          w_size_b;
    logic          w_size_h;
    logic          w_unsigned;
    logic          w_trap;
    logic          w_issue;
    logic          w_ack_taken;
    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_is_load;
    logic          r_size_b;
    logic          r_size_h;
    logic          r_unsigned;
    logic [1:0]    r_off;
    logic [4:0]    r_rd;
    logic          r_reg_write;
    logic [31:0]   r_alu;

    logic          r_wb_valid;
    logic          r_wb_reg_write;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_wb_data;

    logic [7:0]    w_ld_byte;
    logic [15:0]   w_ld_half;
    logic [31:0]   w_ld_data;

    // Decode of the live EX/MEM instruction; a read+write combination behaves as a load.
    assign w_memop    = valid_mem & (mem_read_mem | mem_write_mem);
    assign w_size_b   = (funct3_mem == 3'b000) | (funct3_mem == 3'b100);
    assign w_size_h   = (funct3_mem == 3'b001) | (funct3_mem == 3'b101);
    assign w_unsigned = (funct3_mem == 3'b100) | (funct3_mem == 3'b101);

    // Lane offset with halfword/word accesses snapped down to their natural alignment.
    assign w_off = w_size_b ? alu_result_mem[1:0] :
                   w_size_h ? {alu_result_mem[1], 1'b0} : 2'b00;

`ifdef MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign_exc;

    assign w_misaligned = w_size_h ? alu_result_mem[0] :
                          (~w_size_b & (alu_result_mem[1:0] != 2'b00));
    assign w_trap       = w_memop & w_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_exc <= 1'b0;
        end else begin
            r_misalign_exc <= (r_state == ST_IDLE) & w_trap;
        end
    end

    assign misalign_exc = r_misalign_exc;
`else
    assign w_trap       = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    assign w_issue     = (r_state == ST_IDLE) & w_memop & ~w_trap;
    assign w_ack_taken = (r_state == ST_REQ) & dmem_ack;
    assign mem_stall   = w_issue | ((r_state == ST_REQ) & ~dmem_ack);

    assign w_be = mem_read_mem ? 4'b1111 :
                  w_size_b     ? (4'b0001 << w_off) :
                  w_size_h     ? (4'b0011 << w_off) : 4'b1111;

    // Store data replicated across lanes so the memory only has to honour byte enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign w_wdata[8*gi +: 8] = w_size_b ? rs2_data_mem[7:0] :
                                    w_size_h ? rs2_data_mem[8*(gi%2) +: 8] :
                                               rs2_data_mem[8*gi +: 8];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue)  w_state_next = ST_REQ;
            ST_REQ:  if (dmem_ack) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request fields are captured once at issue and held untouched until the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_is_load   <= 1'b0;
            r_size_b    <= 1'b0;
            r_size_h    <= 1'b0;
            r_unsigned  <= 1'b0;
            r_off       <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_alu       <= '0;
        end else if (w_issue) begin
            r_we        <= ~mem_read_mem;
            r_addr      <= {alu_result_mem[AW-1:2], 2'b00};
            r_wdata     <= w_wdata;
            r_be        <= w_be;
            r_is_load   <= mem_read_mem;
            r_size_b    <= w_size_b;
            r_size_h    <= w_size_h;
            r_unsigned  <= w_unsigned;
            r_off       <= w_off;
            r_rd        <= rd_mem;
            r_reg_write <= reg_write_mem;
            r_alu       <= alu_result_mem;
        end
    end

    assign w_ld_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    assign w_ld_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = dmem_rdata;
        if (r_size_b) begin
            w_ld_data = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
        end else if (r_size_h) begin
            w_ld_data = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
        end
    end

    // MEM/WB register: bubbles keep rd/data but clear valid and write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_memop) begin
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
            end else begin
                r_wb_valid     <= valid_mem;
                r_wb_reg_write <= reg_write_mem & valid_mem;
                r_wb_rd        <= rd_mem;
                r_wb_data      <= alu_result_mem;
            end
        end else if (w_ack_taken) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= r_reg_write & r_is_load;
            r_wb_rd        <= r_rd;
            r_wb_data      <= r_is_load ? w_ld_data : r_alu;
        end else begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
        end
    end

    assign dmem_req         = (r_state == ST_REQ);
    assign dmem_we          = r_we;
    assign dmem_addr        = r_addr;
    assign dmem_wdata       = r_wdata;
    assign dmem_be          = r_be;
    assign data_forward_mem = alu_result_mem;
    assign wb_valid         = r_wb_valid;
    assign wb_reg_write     = r_wb_reg_write;
    assign wb_rd            = r_wb_rd;
    assign wb_data          = r_wb_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops against a
// byte-lane memory model; the bench itself plays the data memory on the req/ack bus.
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_mem;
    logic [31:0]   alu_result_mem;
    logic [31:0]   rs2_data_mem;
    logic          mem_read_mem;
    logic          mem_write_mem;
    logic [2:0]    funct3_mem;
    logic [4:0]    rd_mem;
    logic          reg_write_mem;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_be;
    logic [31:0]   dmem_rdata;
    logic          dmem_ack;
    logic          mem_stall;
    logic [31:0]   data_forward_mem;
    logic          wb_valid;
    logic          wb_reg_write;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          misalign_exc;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model [int];

    mem_access_stage #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .valid_mem(valid_mem), .alu_result_mem(alu_result_mem),
        .rs2_data_mem(rs2_data_mem), .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
        .funct3_mem(funct3_mem), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
        .data_forward_mem(data_forward_mem), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
        int o;
        o = int'(a % 4);
        return o - (o % size_of(f3));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] a);
        int s;
        longint unsigned w64;
        longint unsigned v;
        s   = size_of(f3);
        w64 = word;
        v   = (w64 >> (8 * eff_off(f3, a))) % (64'd1 << (8 * s));
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'd1 << (8 * s - 1)))
            v = v - (64'd1 << (8 * s));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic is_ld, input logic [2:0] f3,
                                          input logic [31:0] a);
        int m;
        if (is_ld) return 4'hF;
        m = (1 << size_of(f3)) - 1;
        return 4'(m << eff_off(f3, a));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int s;
        longint unsigned r64;
        longint unsigned lane;
        longint unsigned acc;
        s   = size_of(f3);
        r64 = rs2;
        acc = 0;
        lane = r64 % (64'd1 << (8 * s));
        for (int i = 0; i < 4 / s; i++) acc += lane << (8 * s * i);
        return acc[31:0];
    endfunction

    // ---------------- transaction drivers ----------------
    task automatic alu_op(input logic v, input logic [31:0] res, input logic [4:0] rd,
                          input logic rw, input logic rdf, input logic wrf,
                          input logic spurious_ack, input string tag);
        valid_mem      = v;
        alu_result_mem = res;
        rd_mem         = rd;
        reg_write_mem  = rw;
        mem_read_mem   = v ? 1'b0 : rdf;
        mem_write_mem  = v ? 1'b0 : wrf;
        rs2_data_mem   = $urandom;
        funct3_mem     = 3'($urandom_range(0, 7));
        dmem_ack       = spurious_ack;
        dmem_rdata     = $urandom;
        $display("[%0t] %s v=%0d res=%h rd=%0d rw=%0d ack=%0d", $time, tag, v, res, rd, rw, spurious_ack);
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b0 || data_forward_mem !== res)
            begin errors++; $display("FAIL %s idle: stall=%b req=%b fwd=%h, required 0 0 %h", tag, mem_stall, dmem_req, data_forward_mem, res); end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== v || wb_reg_write !== (rw & v) || wb_rd !== rd || wb_data !== res || misalign_exc !== 1'b0)
            begin errors++; $display("FAIL %s wb: v=%b we=%b rd=%0d data=%h exc=%b, required %b %b %0d %h 0", tag, wb_valid, wb_reg_write, wb_rd, wb_data, misalign_exc, v, rw & v, rd, res); end
    endtask

    task automatic mem_op(input logic rd_f, input logic wr_f, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rw, input int delay, input string tag);
        logic [31:0] exp_addr, exp_wdata, word, exp_data;
        logic [3:0]  exp_be;
        logic        is_ld;
        int          key;
        int          stalls;
        is_ld     = rd_f;
        exp_addr  = addr & 32'hFFFF_FFFC;
        key       = int'(exp_addr >> 2);
        if (!mem_model.exists(key)) mem_model[key] = $urandom;
        exp_be    = ref_be(is_ld, f3, addr);
        exp_wdata = ref_wdata(f3, rs2);
        valid_mem      = 1'b1;
        alu_result_mem = addr;
        rs2_data_mem   = rs2;
        mem_read_mem   = rd_f;
        mem_write_mem  = wr_f;
        funct3_mem     = f3;
        rd_mem         = rd;
        reg_write_mem  = rw;
        dmem_ack       = 1'b0;
        $display("[%0t] %s ld=%0d f3=%0d addr=%h rs2=%h rd=%0d delay=%0d", $time, tag, is_ld, f3, addr, rs2, rd, delay);
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        if (is_misaligned(f3, addr)) begin
            checks++;
            if (mem_stall !== 1'b0 || dmem_req !== 1'b0)
                begin errors++; $display("FAIL %s trap issue: stall=%b req=%b, required 0 0", tag, mem_stall, dmem_req); end
            @(posedge clk); #1;
            checks++;
            if (misalign_exc !== 1'b1 || wb_valid !== 1'b0 || dmem_req !== 1'b0)
                begin errors++; $display("FAIL %s trap: exc=%b wb_valid=%b req=%b, required 1 0 0", tag, misalign_exc, wb_valid, dmem_req); end
            valid_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
            return;
        end
`endif
        stalls = 0;
        checks++;
        if (mem_stall !== 1'b1 || dmem_req !== 1'b0)
            begin errors++; $display("FAIL %s issue: stall=%b req=%b, required 1 0", tag, mem_stall, dmem_req); end
        if (mem_stall === 1'b1) stalls++;
        @(posedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0)
            begin errors++; $display("FAIL %s issue bubble: wb_valid=%b, required 0", tag, wb_valid); end
        word = mem_model[key];
        for (int k = 0; k <= delay; k++) begin
            if (k == delay) begin dmem_ack = 1'b1; dmem_rdata = word; end
            else dmem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== ~is_ld || dmem_addr !== exp_addr[AW-1:0] ||
                dmem_be !== exp_be || (!is_ld && dmem_wdata !== exp_wdata) || data_forward_mem !== addr)
                begin errors++; $display("FAIL %s bus cyc%0d: req=%b we=%b addr=%h be=%b wdata=%h, required 1 %b %h %b %h", tag, k, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ~is_ld, exp_addr, exp_be, exp_wdata); end
            checks++;
            if (mem_stall !== (k != delay))
                begin errors++; $display("FAIL %s stall cyc%0d: got %b required %b", tag, k, mem_stall, k != delay); end
            if (mem_stall === 1'b1) stalls++;
            @(posedge clk); #1;
            if (k < delay) begin
                checks++;
                if (wb_valid !== 1'b0)
                    begin errors++; $display("FAIL %s wait bubble cyc%0d: wb_valid=%b, required 0", tag, k, wb_valid); end
            end
        end
        dmem_ack = 1'b0; valid_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        if (!is_ld) begin
            for (int b = 0; b < 4; b++) if (exp_be[b]) word[8*b +: 8] = exp_wdata[8*b +: 8];
            mem_model[key] = word;
        end
        exp_data = ref_load(mem_model[key], f3, addr);
        checks++;
        if (wb_valid !== 1'b1 || wb_reg_write !== (rw & is_ld) || wb_rd !== rd || (is_ld && wb_data !== exp_data))
            begin errors++; $display("FAIL %s result: v=%b we=%b rd=%0d data=%h, required 1 %b %0d %h", tag, wb_valid, wb_reg_write, wb_rd, wb_data, rw & is_ld, rd, exp_data); end
        checks++;
        if (stalls != delay + 1)
            begin errors++; $display("FAIL %s stall count: got %0d required %0d", tag, stalls, delay + 1); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        valid_mem = 1'b0; alu_result_mem = '0; rs2_data_mem = '0; mem_read_mem = 1'b0;
        mem_write_mem = 1'b0; funct3_mem = '0; rd_mem = '0; reg_write_mem = 1'b0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== '0 || dmem_wdata !== '0 ||
            dmem_be !== '0 || wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_rd !== '0 ||
            wb_data !== '0 || misalign_exc !== 1'b0 || mem_stall !== 1'b0)
            begin errors++; $display("FAIL reset: req=%b we=%b addr=%h wdata=%h be=%b wbv=%b wbw=%b rd=%0d data=%h exc=%b stall=%b, required all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_reg_write, wb_rd, wb_data, misalign_exc, mem_stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        alu_op(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, "add");
        alu_op(1'b1, 32'hCAFE_0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, "add_x0_stray_ack");
        alu_op(1'b0, 32'h0000_0104, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, "bubble_flags");
    endtask

    task automatic test_load_byte();
        mem_model[32'h100 >> 2] = 32'h80AA_BBCC;
        mem_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 3, "lb");
        checks++;
        if (wb_data !== 32'hFFFF_FF80)
            begin errors++; $display("FAIL lb value: got %h required ffffff80", wb_data); end
        mem_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 1'b1, 3, "lbu");
        checks++;
        if (wb_data !== 32'h0000_0080)
            begin errors++; $display("FAIL lbu value: got %h required 00000080", wb_data); end
    endtask

    task automatic test_store_half();
        mem_op(1'b0, 1'b1, 3'b001, 32'h22, 32'hDEAD_BEEF, 5'd4, 1'b1, 0, "sh");
        checks++;
        if (wb_reg_write !== 1'b0 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF)
            begin errors++; $display("FAIL sh lanes: we=%b be=%b wdata=%h, required 0 1100 beefbeef", wb_reg_write, dmem_be, dmem_wdata); end
        mem_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd6, 1'b1, 1, "lw_after_sh");
        checks++;
        if (wb_data[31:16] !== 16'hBEEF)
            begin errors++; $display("FAIL sh readback: got %h required beef", wb_data[31:16]); end
    endtask

    task automatic test_back_to_back();
        logic wbv_log [$];
        logic [5:0] got;
        fork
            begin
                @(posedge clk);
                repeat (6) begin @(negedge clk); wbv_log.push_back(wb_valid); end
            end
        join_none
        mem_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd10, 1'b1, 0, "b2b_lw");
        mem_op(1'b0, 1'b1, 3'b010, 32'h304, 32'h1357_9BDF, 5'd11, 1'b0, 2, "b2b_sw");
        @(negedge clk);
        got = '0;
        for (int i = 0; i < 6 && i < wbv_log.size(); i++) got[5 - i] = wbv_log[i];
        checks++;
        if (wbv_log.size() != 6 || got !== 6'b010001)
            begin errors++; $display("FAIL b2b wb_valid pattern: got %b (%0d samples) required 010001", got, wbv_log.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        mem_model[32'h40 >> 2] = 32'h1122_3344;
        mem_op(1'b1, 1'b0, 3'b010, 32'h41, 32'h0, 5'd9, 1'b1, 1, "lw_misalign");
`ifndef MISALIGN_TRAP_EN
        checks++;
        if (wb_data !== 32'h1122_3344 || dmem_addr !== 32'h40)
            begin errors++; $display("FAIL lw_misalign forced: data=%h addr=%h, required 11223344 00000040", wb_data, dmem_addr); end
`endif
        alu_op(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "after_misalign");
    endtask

    task automatic test_reset_mid_req();
        valid_mem = 1'b1; alu_result_mem = 32'h400; mem_read_mem = 1'b1; mem_write_mem = 1'b0;
        funct3_mem = 3'b010; rd_mem = 5'd12; reg_write_mem = 1'b1; dmem_ack = 1'b0;
        $display("[%0t] reset_mid_req lw addr=00000400", $time);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1)
            begin errors++; $display("FAIL reset_mid_req pre: req=%b required 1", dmem_req); end
        rst = 1'b1; valid_mem = 1'b0; mem_read_mem = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0)
            begin errors++; $display("FAIL reset_mid_req post: req=%b wbv=%b stall=%b, required 0 0 0", dmem_req, wb_valid, mem_stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a    = 32'h200 + 32'($urandom_range(0, 31));
            case (kind)
                0: alu_op(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'($urandom), "rnd_alu");
                1: alu_op(1'b0, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rnd_bubble");
                2: mem_op(1'b1, 1'b0, f3_tab[$urandom_range(0, 7)], a, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3), "rnd_load");
                3: mem_op(1'b0, 1'b1, f3_tab[$urandom_range(0, 7)], a, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3), "rnd_store");
                default: mem_op(1'b1, 1'b1, f3_tab[$urandom_range(0, 7)], a, $urandom, 5'($urandom), 1'b1, $urandom_range(0, 3), "rnd_rw_as_load");
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_back_to_back();
        test_misalign();
        test_reset_mid_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
